// File: rtl/sccb_pkg.sv
// Constants shared by the SCCB configuration sequencer and its register table ROM.
package sccb_pkg;

    localparam logic [15:0] END_MARKER   = 16'hFFFF;
    localparam logic [15:0] DELAY_MARKER = 16'hFFF0;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_FETCH     = 3'd1;
    localparam logic [2:0] ST_DECODE    = 3'd2;
    localparam logic [2:0] ST_ISSUE     = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;
    localparam logic [2:0] ST_DELAY     = 3'd5;
    localparam logic [2:0] ST_FINISH    = 3'd6;
    localparam logic [2:0] ST_ERROR     = 3'd7;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cfg_entry_t;

    function automatic cfg_entry_t cfg_write(input logic [7:0] reg_addr, input logic [7:0] data);
        cfg_entry_t entry;
        entry.reg_addr = reg_addr;
        entry.data     = data;
        return entry;
    endfunction

endpackage

// File: rtl/sccb_cfg_rom.sv
// Camera register table: {reg_addr, data} entries, synchronous read with one cycle of latency.
module sccb_cfg_rom
    import sccb_pkg::*;
#(
    parameter int ADDR_W = 8
)(
    input  logic              i_clk,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [15:0]       o_data
);

    logic [15:0] w_entry;
    logic [15:0] r_data;

    // Soft reset first and let the sensor settle before the remaining writes.
    always_comb begin
        w_entry = END_MARKER;
        case (32'(i_addr))
            32'd0:   w_entry = cfg_write(8'h12, 8'h80);
            32'd1:   w_entry = DELAY_MARKER;
            32'd2:   w_entry = cfg_write(8'h12, 8'h04);
            32'd3:   w_entry = cfg_write(8'h11, 8'h01);
            32'd4:   w_entry = cfg_write(8'h40, 8'hD0);
            32'd5:   w_entry = cfg_write(8'h3A, 8'h04);
            32'd6:   w_entry = cfg_write(8'h8C, 8'h00);
            default: w_entry = END_MARKER;
        endcase
    end

    always_ff @(posedge i_clk) begin
        r_data <= w_entry;
    end

    assign o_data = r_data;

endmodule

// File: rtl/sccb_cfg_seq.sv
// Walks the register table and hands each {SLAVE_ADDR, reg, data} write to the SCCB core,
// honouring delay entries, the end marker and a per-transaction completion timeout.
module sccb_cfg_seq
    import sccb_pkg::*;
#(
    parameter logic [7:0] SLAVE_ADDR     = 8'h42,
    parameter int         ADDR_W         = 8,
    parameter int         DELAY_CYCLES   = 4000,
    parameter int         TIMEOUT_CYCLES = 1024
)(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_cfg_start,
    output logic [ADDR_W-1:0] o_rom_addr,
    input  logic [15:0]       i_rom_data,
    output logic              o_i2c_start,
    output logic [23:0]       o_i2c_data,
    input  logic              i_i2c_done,
    output logic              o_busy,
    output logic              o_cfg_done,
    output logic              o_cfg_err
);

    localparam int                TO_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;
    localparam logic [15:0]       DELAY_LOAD = 16'(DELAY_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_i2c_start;
    logic [23:0]       r_i2c_data;
    logic              r_busy;
    logic              r_cfg_done;
    logic              r_cfg_err;
    logic [15:0]       r_delay_cnt;
    logic [TO_W-1:0]   r_timeout_cnt;
    logic              w_at_last;

    assign w_at_last = (r_rom_addr == LAST_ADDR);

    // The start pulse is raised on the DECODE->ISSUE edge so it is high exactly while in ISSUE.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state       <= ST_IDLE;
            r_rom_addr    <= '0;
            r_i2c_start   <= 1'b0;
            r_i2c_data    <= '0;
            r_busy        <= 1'b0;
            r_cfg_done    <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_delay_cnt   <= '0;
            r_timeout_cnt <= '0;
        end else begin
            r_i2c_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_cfg_start) begin
                        r_rom_addr <= '0;
                        r_cfg_done <= 1'b0;
                        r_cfg_err  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_FETCH;
                    end
                end
                ST_FETCH: r_state <= ST_DECODE;
                ST_DECODE: begin
                    if (i_rom_data == END_MARKER) begin
                        r_state <= ST_FINISH;
                    end else if (i_rom_data == DELAY_MARKER) begin
                        r_delay_cnt <= DELAY_LOAD;
                        r_state     <= ST_DELAY;
                    end else begin
                        r_i2c_data  <= {SLAVE_ADDR, i_rom_data};
                        r_i2c_start <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_timeout_cnt <= '0;
                    r_state       <= ST_WAIT_DONE;
                end
                // A done pulse on the final timeout cycle still wins over the timeout.
                ST_WAIT_DONE: begin
                    if (i_i2c_done) begin
                        r_state <= w_at_last ? ST_FINISH : ST_FETCH;
                        if (!w_at_last) r_rom_addr <= r_rom_addr + 1'b1;
                    end else if (r_timeout_cnt == TO_LAST) begin
                        r_state <= ST_ERROR;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (r_delay_cnt == '0) begin
                        r_state <= w_at_last ? ST_FINISH : ST_FETCH;
                        if (!w_at_last) r_rom_addr <= r_rom_addr + 1'b1;
                    end else begin
                        r_delay_cnt <= r_delay_cnt - 1'b1;
                    end
                end
                ST_FINISH: begin
                    r_cfg_done <= 1'b1;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                ST_ERROR: begin
                    r_cfg_err <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_rom_addr  = r_rom_addr;
    assign o_i2c_start = r_i2c_start;
    assign o_i2c_data  = r_i2c_data;
    assign o_busy      = r_busy;
    assign o_cfg_done  = r_cfg_done;
    assign o_cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_sccb_cfg_seq.sv
// Self-checking bench for sccb_cfg_seq: table ROM and SCCB core are modelled here,
// expected transactions and their cycle positions come from a schedule model of the table.
module tb_sccb_cfg_seq;

    localparam int          ADDR_W         = 2;
    localparam int          DEPTH          = 4;
    localparam int          DELAY_CYCLES   = 4000;
    localparam int          TIMEOUT_CYCLES = 1024;
    localparam logic [7:0]  SLAVE_ADDR     = 8'h42;
    localparam logic [15:0] TB_END         = 16'hFFFF;
    localparam logic [15:0] TB_DELAY       = 16'hFFF0;
    localparam int          RUN_BOUND      = 25000;
    localparam logic [15:0] ROM_EXP [4]    = '{16'h1280, 16'hFFF0, 16'h1204, 16'h1101};

    logic              clk = 1'b0;
    logic              rstn;
    logic              cfg_start;
    logic [ADDR_W-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              i2c_start;
    logic [23:0]       i2c_data;
    logic              i2c_done;
    logic              busy;
    logic              cfg_done;
    logic              cfg_err;
    logic [1:0]        probeAddr;
    logic [15:0]       probeData;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [15:0] table_mem [DEPTH];
    int          coreLatency;
    logic        forceDone;
    int          remaining;
    logic [23:0] heldData;
    int          unstable;
    int          startCyc [$];
    logic [23:0] startData [$];

    int          expStart [$];
    logic [23:0] expData [$];
    bit          expErr;
    int          expFlag;
    int          expAddr;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) rom_data <= table_mem[rom_addr];

    sccb_cfg_seq #(
        .SLAVE_ADDR(SLAVE_ADDR),
        .ADDR_W(ADDR_W),
        .DELAY_CYCLES(DELAY_CYCLES),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clk(clk),
        .i_rstn(rstn),
        .i_cfg_start(cfg_start),
        .o_rom_addr(rom_addr),
        .i_rom_data(rom_data),
        .o_i2c_start(i2c_start),
        .o_i2c_data(i2c_data),
        .i_i2c_done(i2c_done),
        .o_busy(busy),
        .o_cfg_done(cfg_done),
        .o_cfg_err(cfg_err)
    );

    sccb_cfg_rom #(.ADDR_W(2)) rom (
        .i_clk(clk),
        .i_addr(probeAddr),
        .o_data(probeData)
    );

    // SCCB core model: done pulses coreLatency cycles after a start (0 = never answers).
    always @(negedge clk) begin
        i2c_done = forceDone;
        if (!rstn) begin
            remaining = 0;
        end else begin
            if (remaining > 0) begin
                if (i2c_data !== heldData) unstable++;
                remaining--;
                if (remaining == 0) i2c_done = 1'b1;
            end
            if (i2c_start === 1'b1) begin
                startCyc.push_back(cyc);
                startData.push_back(i2c_data);
                heldData  = i2c_data;
                remaining = coreLatency;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic loadTable(input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3);
        table_mem[0] = e0;
        table_mem[1] = e1;
        table_mem[2] = e2;
        table_mem[3] = e3;
    endtask

    // Schedule model, cycles relative to the cycle cfg_start is high: each entry costs a fetch and
    // a decode cycle, a write then issues, a delay entry waits DELAY_CYCLES, the flags appear one
    // cycle after the terminating FINISH/ERROR cycle.
    function automatic void predict(input int latency);
        int t;
        bit stop;
        t    = 1;
        stop = 0;
        expStart.delete();
        expData.delete();
        expErr  = 0;
        expAddr = DEPTH - 1;
        expFlag = 0;
        for (int idx = 0; idx < DEPTH && !stop; idx++) begin
            if (table_mem[idx] == TB_END) begin
                expFlag = t + 3;
                expAddr = idx;
                stop    = 1;
            end else if (table_mem[idx] == TB_DELAY) begin
                t = t + 2 + DELAY_CYCLES;
            end else begin
                expStart.push_back(t + 2);
                expData.push_back({SLAVE_ADDR, table_mem[idx]});
                if (latency < 1 || latency > TIMEOUT_CYCLES) begin
                    expErr  = 1;
                    expFlag = t + 2 + TIMEOUT_CYCLES + 2;
                    expAddr = idx;
                    stop    = 1;
                end else begin
                    t = t + 3 + latency;
                end
            end
        end
        if (!stop) expFlag = t + 1;
    endfunction

    task automatic applyStimulus(input string name, input int latency, input bit midPulse);
        int  c;
        int  flagCyc;
        bit  seen;
        coreLatency = latency;
        startCyc.delete();
        startData.delete();
        unstable = 0;
        @(negedge clk);
        cfg_start = 1'b1;
        c = cyc;
        @(negedge clk);
        cfg_start = 1'b0;
        checkOutput({name, " busy after start"}, 32'(busy), 32'd1);
        seen    = 0;
        flagCyc = 0;
        for (int t = 0; t < RUN_BOUND && !seen; t++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            if (midPulse && startCyc.size() == 1) begin
                if (cyc == startCyc[0] + 5) cfg_start = 1'b1;
            end
            if (cfg_done || cfg_err) begin
                seen    = 1;
                flagCyc = cyc - c;
            end
        end
        cfg_start = 1'b0;
        checkOutput({name, " completes in bound"}, 32'(seen), 32'd1);
        repeat (40) @(negedge clk);
        predict(latency);
        checkOutput({name, " start count"}, 32'(startCyc.size()), 32'(expStart.size()));
        for (int i = 0; i < startCyc.size() && i < expStart.size(); i++) begin
            checkOutput($sformatf("%s start%0d cycle", name, i), 32'(startCyc[i] - c), 32'(expStart[i]));
            checkOutput($sformatf("%s start%0d data", name, i), 32'(startData[i]), 32'(expData[i]));
        end
        checkOutput({name, " cfg_done"}, 32'(cfg_done), 32'(!expErr));
        checkOutput({name, " cfg_err"}, 32'(cfg_err), 32'(expErr));
        checkOutput({name, " busy after end"}, 32'(busy), 32'd0);
        checkOutput({name, " flag cycle"}, 32'(flagCyc), 32'(expFlag));
        checkOutput({name, " rom_addr"}, 32'(rom_addr), 32'(expAddr));
        checkOutput({name, " data stable"}, 32'(unstable), 32'd0);
    endtask

    task automatic checkResetOutputs(input string name);
        checkOutput({name, " i2c_start"}, 32'(i2c_start), 32'd0);
        checkOutput({name, " i2c_data"}, 32'(i2c_data), 32'd0);
        checkOutput({name, " busy"}, 32'(busy), 32'd0);
        checkOutput({name, " cfg_done"}, 32'(cfg_done), 32'd0);
        checkOutput({name, " cfg_err"}, 32'(cfg_err), 32'd0);
        checkOutput({name, " rom_addr"}, 32'(rom_addr), 32'd0);
    endtask

    initial begin
        logic [15:0] v [DEPTH];
        int          lat;
        int          waited;
        rstn        = 1'b0;
        cfg_start   = 1'b0;
        forceDone   = 1'b0;
        coreLatency = 30;
        remaining   = 0;
        unstable    = 0;
        heldData    = '0;
        probeAddr   = 2'd0;
        loadTable(TB_END, TB_END, TB_END, TB_END);
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        rstn = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            probeAddr = 2'(i);
            @(negedge clk);
            checkOutput($sformatf("rom entry%0d", i), 32'(probeData), 32'(ROM_EXP[i]));
        end

        $display("[TB] two writes then end marker");
        loadTable(16'h1280, 16'h1101, TB_END, 16'h0000);
        applyStimulus("basic", 30, 0);

        $display("[TB] delay entry between writes");
        loadTable(16'h1280, TB_DELAY, 16'h1101, TB_END);
        applyStimulus("delay", 30, 0);

        $display("[TB] core never answers");
        loadTable(16'h1280, 16'h1101, TB_END, 16'h0000);
        applyStimulus("timeout", 0, 0);

        $display("[TB] done on the last timeout cycle");
        loadTable(16'h3A04, TB_END, 16'h0000, 16'h0000);
        applyStimulus("late done ok", TIMEOUT_CYCLES, 0);
        applyStimulus("late done err", TIMEOUT_CYCLES + 1, 0);

        $display("[TB] table without end marker");
        loadTable(16'h1280, 16'h1101, 16'h3A04, 16'h40D0);
        applyStimulus("no end", 7, 0);

        $display("[TB] cfg_start during transaction");
        loadTable(16'h1280, 16'h1101, TB_END, 16'h0000);
        applyStimulus("restart ignored", 30, 1);

        $display("[TB] stray done while idle");
        forceDone = 1'b1;
        repeat (2) @(negedge clk);
        forceDone = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("stray done busy", 32'(busy), 32'd0);
        checkOutput("stray done cfg_done", 32'(cfg_done), 32'd1);
        checkOutput("stray done starts", 32'(startCyc.size()), 32'd2);

        $display("[TB] reset during transaction");
        coreLatency = 30;
        startCyc.delete();
        startData.delete();
        @(negedge clk);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        waited = 0;
        while (startCyc.size() < 2 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("mid reset reached second write", 32'(startCyc.size()), 32'd2);
        repeat (5) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checkResetOutputs("mid reset");
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("mid reset stays idle", 32'(busy), 32'd0);
        applyStimulus("after reset", 30, 0);

        $display("[TB] randomized tables");
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < DEPTH; i++) begin
                case ($urandom_range(0, 11))
                    0:       v[i] = TB_END;
                    1:       v[i] = TB_DELAY;
                    default: begin
                        v[i] = 16'($urandom);
                        if (v[i] == TB_END || v[i] == TB_DELAY) v[i] = 16'h1234;
                    end
                endcase
            end
            loadTable(v[0], v[1], v[2], v[3]);
            lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 40));
            applyStimulus($sformatf("random%0d", r), lat, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_cfg_seq.md
SCCB_CFG_SEQ -- requirements
Module: sccb_cfg_seq

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 8'h42, the SCCB write address placed in i2c_data[23:16].
REQ-002 SHALL have parameter ADDR_W, default 8, the table address width (ROM depth 2^ADDR_W entries).
REQ-003 SHALL have parameter DELAY_CYCLES, default 4000, the wait length for a delay entry (10 ms at 400 kHz).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, the maximum wait from i2c_start to i2c_done.
REQ-005 clk  in  1  single clock, same 400 kHz tick clock as the SCCB core.
REQ-006 rstn  in  1  synchronous, active-low reset.
REQ-007 cfg_start  in  1  one-cycle request to run the configuration table from entry 0.
REQ-008 rom_addr  out  ADDR_W  table read address.
REQ-009 rom_data  in  16  table entry {reg_addr[7:0], data[7:0]}, valid one cycle after rom_addr changes.
REQ-010 i2c_start  out  1  one-cycle transaction request to the SCCB core.
REQ-011 i2c_data  out  24  {SLAVE_ADDR, reg_addr, data} for the SCCB core.
REQ-012 i2c_done  in  1  one-cycle completion pulse from the SCCB core.
REQ-013 busy  out  1  high from accepted cfg_start until FINISH or ERROR.
REQ-014 cfg_done  out  1  level; table completed successfully.
REQ-015 cfg_err  out  1  level; aborted on timeout.

Function
REQ-016 States: IDLE, FETCH, DECODE, ISSUE, WAIT_DONE, DELAY, FINISH, ERROR.
REQ-017 IDLE: cfg_start=1 -> rom_addr<=0, cfg_done<=0, cfg_err<=0, busy<=1, go to FETCH; cfg_start ignored in all other states.
REQ-018 FETCH: one wait cycle for ROM latency, then DECODE.
REQ-019 DECODE: rom_data==16'hFFFF -> FINISH (end marker, no transaction issued).
REQ-020 DECODE: rom_data==16'hFFF0 -> load delay counter with DELAY_CYCLES-1, go to DELAY.
REQ-021 DECODE: any other value -> i2c_data<={SLAVE_ADDR, rom_data}, go to ISSUE.
REQ-022 ISSUE: i2c_start=1 for exactly one cycle, timeout counter cleared, go to WAIT_DONE.
REQ-023 i2c_data SHALL stay stable from ISSUE until i2c_done is sampled.
REQ-024 WAIT_DONE: i2c_done=1 -> advance; timeout counter reaching TIMEOUT_CYCLES-1 without i2c_done -> ERROR.
REQ-025 DELAY: count down to 0, then advance.
REQ-026 Advance: rom_addr==2^ADDR_W-1 -> FINISH (no wrap to 0); otherwise rom_addr<=rom_addr+1, go to FETCH.
REQ-027 The FETCH/DECODE cycles after i2c_done guarantee at least two idle cycles before the next i2c_start, so the core has returned to idle.
REQ-028 FINISH: cfg_done<=1, busy<=0, go to IDLE; cfg_done holds until the next accepted cfg_start.
REQ-029 ERROR: cfg_err<=1, busy<=0, go to IDLE; cfg_err holds until the next accepted cfg_start.
REQ-030 i2c_done arriving in any state other than WAIT_DONE SHALL be ignored.
REQ-031 i2c_done and the timeout expiring in the same cycle SHALL count as success.
REQ-032 Counters: delay counter 16 bits, timeout counter clog2(TIMEOUT_CYCLES) bits, both unsigned, no wrap.

Reset
REQ-033 rstn=0 at a clk edge: state<=IDLE, rom_addr<=0, i2c_start<=0, i2c_data<=0, busy<=0, cfg_done<=0, cfg_err<=0, counters<=0.
REQ-034 Reset asserted mid-transaction SHALL deassert i2c_start immediately; the table restarts only on a new cfg_start.

Structure
REQ-035 End marker 16'hFFFF, delay marker 16'hFFF0, and the state encodings SHALL live in a shared package (sccb_pkg) also used by the table ROM.
REQ-036 The table SHALL be a separate sub-module, sccb_cfg_rom (synchronous read, 1-cycle latency), instantiated beside this block, not inside it.

Verification
REQ-037 Table {0x1280, 0x1101, 0xFFFF}; core model returns done 30 cycles after start -> two starts, i2c_data 0x421280 then 0x421101, cfg_done=1, cfg_err=0.
REQ-038 Table {0x1280, 0xFFF0, 0x1101, 0xFFFF}, DELAY_CYCLES=4000 -> gap from first done to second start is 4000 cycles plus fixed overhead; exactly two starts.
REQ-039 Core model never asserts done, TIMEOUT_CYCLES=1024 -> cfg_err=1 after 1024 cycles, busy=0, no further i2c_start pulses.
REQ-040 Table with no end marker, ADDR_W=2 -> exactly 4 transactions, rom_addr stops at 3, cfg_done=1.
REQ-041 cfg_start pulsed during WAIT_DONE -> ignored; i2c_start sequence unchanged.
REQ-042 rstn low during WAIT_DONE -> all outputs at reset values next cycle; a new cfg_start restarts from rom_addr 0.
